// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared definitions for the EQ gain mixer:
//   - eq_state_e  : controller states (IDLE, MAC, SCALE, OUT)
//   - acc_width() : accumulator width that cannot overflow for a band sum
//   - SAT_*       : bit patterns that build the +max / -min output limits
// -----------------------------------------------------------------------------
package eq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_SCALE = 2'd2,
        ST_OUT   = 2'd3
    } eq_state_e;

    // Full-precision product plus enough headroom for NUM_BANDS additions.
    function automatic int acc_width(input int in_w, input int gain_w, input int num_bands);
        return in_w + gain_w + $clog2(num_bands);
    endfunction

    // Saturation limits are {sign, fill...}: +max = 0111..1, -min = 1000..0.
    localparam logic SAT_POS_SIGN = 1'b0;
    localparam logic SAT_POS_FILL = 1'b1;
    localparam logic SAT_NEG_SIGN = 1'b1;
    localparam logic SAT_NEG_FILL = 1'b0;

endpackage

// File: rtl/eq_chan_mac.sv
// -----------------------------------------------------------------------------
// eq_chan_mac
// One channel of the mixer: multiply-accumulate over the bands, barrel shift
// of the sum, selection of the output window and (optionally) saturation.
// Build option: EQ_GAIN_MIXER_SATURATE_EN -- clamp instead of wrap.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : clear the accumulator (frame accepted)
//   mac_en       : add sample*gain into the accumulator this cycle
//   cap_en       : shift the sum and capture the output candidate
//   sample, gain : current band sample and its gain (signed)
//   shift        : left-shift amount applied after accumulation
//   cand, sat    : registered candidate sample and its clip indication
// -----------------------------------------------------------------------------
module eq_chan_mac
    import eq_pkg::*;
#(
    parameter int NUM_BANDS = 4,
    parameter int IN_W      = 48,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     mac_en,
    input  logic                     cap_en,
    input  logic signed [IN_W-1:0]   sample,
    input  logic signed [GAIN_W-1:0] gain,
    input  logic [3:0]               shift,
    output logic signed [OUT_W-1:0]  cand,
    output logic                     sat
);
    localparam int PROD_W = IN_W + GAIN_W;
    localparam int ACC_W  = acc_width(IN_W, GAIN_W, NUM_BANDS);
    localparam int SCL_W  = ACC_W + 15;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d, acc_q;
    logic signed [SCL_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  cand_d, cand_q;
    logic                     sat_d, sat_q;
    logic                     unused_scaled;

`ifdef EQ_GAIN_MIXER_SATURATE_EN
    // The window is valid only if every bit above it repeats its sign bit.
    function automatic logic overflows(input logic signed [SCL_W-1:0] v);
        logic [SCL_W-PROD_W:0] top;
        top = v[SCL_W-1:PROD_W-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_limit(input logic neg);
        return neg ? {SAT_NEG_SIGN, {(OUT_W-1){SAT_NEG_FILL}}}
                   : {SAT_POS_SIGN, {(OUT_W-1){SAT_POS_FILL}}};
    endfunction
`endif

    always_comb begin
        prod   = PROD_W'(sample) * PROD_W'(gain);
        scaled = SCL_W'(acc_q) <<< shift;

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        cand_d = cand_q;
        sat_d  = sat_q;
        if (cap_en) begin
`ifdef EQ_GAIN_MIXER_SATURATE_EN
            if (overflows(scaled)) begin
                cand_d = sat_limit(scaled[SCL_W-1]);
                sat_d  = 1'b1;
            end else begin
                cand_d = scaled[PROD_W-1 -: OUT_W];
                sat_d  = 1'b0;
            end
`else
            cand_d = scaled[PROD_W-1 -: OUT_W];
            sat_d  = 1'b0;
`endif
        end
    end

    // ---- accumulator / candidate registers ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q  <= '0;
            cand_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cand_q <= cand_d;
            sat_q  <= sat_d;
        end
    end

    // Bits below the output window (and above it when wrapping) are dropped.
    assign unused_scaled = ^scaled;
    assign cand          = cand_q;
    assign sat           = sat_q;

endmodule

// File: rtl/eq_gain_mixer.sv
// -----------------------------------------------------------------------------
// eq_gain_mixer
// Per-channel gain-weighted sum of NUM_BANDS EQ band samples, one band per
// cycle for all channels in parallel, then shift and output windowing.
// Gains are written into a shadow table and copied to the active table when a
// frame is accepted, so a frame always sees one consistent gain set.
// Build option: EQ_GAIN_MIXER_SATURATE_EN -- clamp outputs and report sat_flag.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   run               : enable; low aborts a frame in MAC/SCALE and blocks input
//   gain_wr*          : shadow gain table write (strobe, channel, band, data)
//   shift             : post-accumulation left shift, latched per frame
//   in_valid/in_ready : frame handshake, in_data = [ch][band] samples
//   out_valid         : one-cycle strobe, out_data held until the next one
//   sat_flag          : a channel clipped in the frame on out_data
//   overrun           : one-cycle pulse, in_valid arrived while not ready
// -----------------------------------------------------------------------------
module eq_gain_mixer
    import eq_pkg::*;
#(
    parameter int  NUM_BANDS = 4,
    parameter int  NUM_CH    = 2,
    parameter int  IN_W      = 48,
    parameter int  GAIN_W    = 16,
    parameter int  OUT_W     = 24,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BAND_W    = $clog2(NUM_BANDS)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              run,
    input  logic                              gain_wr,
    input  logic [CH_W-1:0]                   gain_wr_ch,
    input  logic [BAND_W-1:0]                 gain_wr_band,
    input  logic signed [GAIN_W-1:0]          gain_wr_data,
    input  logic [3:0]                        shift,
    input  logic                              in_valid,
    input  logic [NUM_CH*NUM_BANDS*IN_W-1:0]  in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [NUM_CH*OUT_W-1:0]           out_data,
    output logic                              sat_flag,
    output logic                              overrun
);
    eq_state_e                state_d, state_q;
    logic [BAND_W-1:0]        band_d, band_q;
    logic [3:0]               shift_d, shift_q;
    logic                     init_d, init_q;
    logic signed [GAIN_W-1:0] shadow_d [NUM_CH][NUM_BANDS];
    logic signed [GAIN_W-1:0] shadow_q [NUM_CH][NUM_BANDS];
    logic signed [GAIN_W-1:0] active_d [NUM_CH][NUM_BANDS];
    logic signed [GAIN_W-1:0] active_q [NUM_CH][NUM_BANDS];
    logic signed [IN_W-1:0]   frame_d  [NUM_CH][NUM_BANDS];
    logic signed [IN_W-1:0]   frame_q  [NUM_CH][NUM_BANDS];
    logic [NUM_CH*OUT_W-1:0]  out_data_d, out_data_q;
    logic                     out_valid_d, out_valid_q;
    logic                     sat_flag_d, sat_flag_q;
    logic                     overrun_d, overrun_q;
    logic                     accept, wr_ok, mac_en, cap_en;
    logic signed [OUT_W-1:0]  cand [NUM_CH];
    logic [NUM_CH-1:0]        sat;

    // init_q keeps in_ready low for the first cycle after reset release.
    assign in_ready = (state_q == ST_IDLE) && run && init_q;
    assign accept   = in_valid && in_ready;
    assign wr_ok    = gain_wr && (int'(gain_wr_ch) < NUM_CH) && (int'(gain_wr_band) < NUM_BANDS);
    assign mac_en   = (state_q == ST_MAC);
    assign cap_en   = (state_q == ST_SCALE);

    always_comb begin
        state_d     = state_q;
        band_d      = band_q;
        shift_d     = shift_q;
        init_d      = 1'b1;
        shadow_d    = shadow_q;
        active_d    = active_q;
        frame_d     = frame_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sat_flag_d  = sat_flag_q;
        overrun_d   = in_valid && !in_ready;

        if (wr_ok) begin
            shadow_d[gain_wr_ch][gain_wr_band] = gain_wr_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_MAC;
                    band_d   = '0;
                    shift_d  = shift;
                    // shadow_d already holds a write coincident with acceptance
                    active_d = shadow_d;
                    for (int c = 0; c < NUM_CH; c++) begin
                        for (int b = 0; b < NUM_BANDS; b++) begin
                            frame_d[c][b] = in_data[(c*NUM_BANDS+b)*IN_W +: IN_W];
                        end
                    end
                end
            end
            ST_MAC: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (band_q == BAND_W'(NUM_BANDS-1)) begin
                    state_d = ST_SCALE;
                end else begin
                    band_d = band_q + 1'b1;
                end
            end
            ST_SCALE: begin
                state_d = run ? ST_OUT : ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                sat_flag_d  = |sat;
                for (int c = 0; c < NUM_CH; c++) begin
                    out_data_d[c*OUT_W +: OUT_W] = cand[c];
                end
            end
        endcase
    end

    // ---- control and gain tables ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            band_q      <= '0;
            shift_q     <= '0;
            init_q      <= 1'b0;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            band_q      <= band_d;
            shift_q     <= shift_d;
            init_q      <= init_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_flag_q  <= sat_flag_d;
            overrun_q   <= overrun_d;
        end
    end

    // ---- captured frame samples (data only) ----
    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        eq_chan_mac #(
            .NUM_BANDS (NUM_BANDS),
            .IN_W      (IN_W),
            .GAIN_W    (GAIN_W),
            .OUT_W     (OUT_W)
        ) u_mac (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (accept),
            .mac_en  (mac_en),
            .cap_en  (cap_en),
            .sample  (frame_q[g][band_q]),
            .gain    (active_q[g][band_q]),
            .shift   (shift_q),
            .cand    (cand[g]),
            .sat     (sat[g])
        );
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_flag_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_eq_gain_mixer.sv
module tb_eq_gain_mixer;
    localparam int NB     = 4;
    localparam int NCH    = 2;
    localparam int IN_W   = 48;
    localparam int GAIN_W = 16;
    localparam int OUT_W  = 24;
    localparam int PW     = IN_W + GAIN_W;
    localparam logic signed [127:0] SMAX = (128'sd1 <<< (PW-1)) - 128'sd1;
    localparam logic signed [127:0] SMIN = -(128'sd1 <<< (PW-1));

    logic                     clk = 1'b0;
    logic                     reset_n, run, gain_wr, in_valid;
    logic [0:0]               gain_wr_ch;
    logic [1:0]               gain_wr_band;
    logic signed [GAIN_W-1:0] gain_wr_data;
    logic [3:0]               shift;
    logic [NCH*NB*IN_W-1:0]   in_data;
    logic                     in_ready, out_valid, sat_flag, overrun;
    logic [NCH*OUT_W-1:0]     out_data;

    int ncmp = 0;
    int nfail = 0;

    logic signed [IN_W-1:0]   smp   [NCH][NB];
    logic signed [GAIN_W-1:0] sh_m  [NCH][NB];
    logic signed [GAIN_W-1:0] act_m [NCH][NB];
    logic [OUT_W-1:0]         exp_o [NCH];
    logic                     exp_sat;
    int                       wch, wband;
    logic [GAIN_W-1:0]        wval;
    logic [NCH*OUT_W-1:0]     prev;
    int                       cnt;
    logic [3:0]               rsh;

    eq_gain_mixer #(
        .NUM_BANDS(NB), .NUM_CH(NCH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .gain_wr(gain_wr),
        .gain_wr_ch(gain_wr_ch), .gain_wr_band(gain_wr_band), .gain_wr_data(gain_wr_data),
        .shift(shift), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: weighted sum, multiply by 2**shift, keep the output window;
    // with saturation, clamp whenever the value does not fit a PW-bit number.
    task automatic model_frame(input logic [3:0] sh);
        logic signed [127:0] acc, sc;
        exp_sat = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            acc = '0;
            for (int b = 0; b < NB; b++) begin
                acc = acc + 128'(smp[c][b]) * 128'(act_m[c][b]);
            end
            sc = acc * (128'sd1 << sh);
`ifdef EQ_GAIN_MIXER_SATURATE_EN
            if (sc > SMAX) begin
                exp_o[c] = {1'b0, {(OUT_W-1){1'b1}}};
                exp_sat  = 1'b1;
            end else if (sc < SMIN) begin
                exp_o[c] = {1'b1, {(OUT_W-1){1'b0}}};
                exp_sat  = 1'b1;
            end else begin
                exp_o[c] = sc[PW-1 -: OUT_W];
            end
`else
            exp_o[c] = sc[PW-1 -: OUT_W];
`endif
        end
    endtask

    task automatic drive_wr(input int c, input int b, input logic [GAIN_W-1:0] v);
        gain_wr      = 1'b1;
        gain_wr_ch   = 1'(c);
        gain_wr_band = 2'(b);
        gain_wr_data = v;
        if (c < NCH && b < NB) sh_m[c][b] = v;
    endtask

    task automatic write_gain(input int c, input int b, input logic [GAIN_W-1:0] v);
        drive_wr(c, b, v);
        tick();
        gain_wr = 1'b0;
    endtask

    task automatic rand_gains();
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < NB; b++)
                write_gain(c, b, GAIN_W'($urandom()));
    endtask

    task automatic rand_samples();
        logic [63:0] r;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < NB; b++) begin
                r = {$urandom(), $urandom()};
                smp[c][b] = $signed(r[IN_W-1:0]) >>> $urandom_range(0, 24);
            end
    endtask

    task automatic pack_frame();
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < NB; b++)
                in_data[(c*NB+b)*IN_W +: IN_W] = smp[c][b];
    endtask

    // mode: 0 plain, 1 gain write with acceptance, 2 gain write during MAC,
    //       3 second in_valid two cycles after acceptance
    task automatic do_frame(input logic [3:0] sh, input int mode, input string tag);
        int nv, lat;
        logic [NCH*OUT_W-1:0] seen;
        pack_frame();
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        shift    = sh;
        if (mode == 1) drive_wr(wch, wband, wval);
        act_m = sh_m;
        model_frame(sh);
        tick();
        in_valid = 1'b0;
        gain_wr  = 1'b0;
        nv = 0; lat = 0; seen = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1 && mode == 2) drive_wr(wch, wband, wval);
            if (k == 2 && mode == 3) in_valid = 1'b1;
            tick();
            gain_wr  = 1'b0;
            in_valid = 1'b0;
            if (mode == 3 && k == 2) chk({tag, "_ovr_pulse"}, 64'(overrun), 64'd1);
            if (mode == 3 && k == 3) chk({tag, "_ovr_end"}, 64'(overrun), 64'd0);
            if (out_valid) begin
                nv++;
                if (lat == 0) begin
                    lat  = k;
                    seen = out_data;
                    chk({tag, "_sat"}, 64'(sat_flag), 64'(exp_sat));
                end
            end
        end
        chk({tag, "_nvalid"}, 64'(nv), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(NB + 2));
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_data_ch%0d", tag, c), 64'(seen[c*OUT_W +: OUT_W]), 64'(exp_o[c]));
        chk({tag, "_hold"}, 64'(out_data), 64'(seen));
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b1; gain_wr = 1'b0; gain_wr_ch = '0; gain_wr_band = '0;
        gain_wr_data = '0; shift = '0; in_valid = 1'b0; in_data = '0;
        sh_m = '{default: '0};

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_first_cycle", 64'(in_ready), 64'd0);
        tick();
        chk("ready_after", 64'(in_ready), 64'd1);

        // ---- defaults: band0 = 2^40, gain 0.5 on band0 only ----
        write_gain(0, 0, 16'h4000);
        write_gain(1, 0, 16'h4000);
        rand_samples();
        for (int c = 0; c < NCH; c++) smp[c][0] = 48'sh0100_0000_0000;
        do_frame(4'd0, 0, "dflt");
        chk("dflt_const_ch0", 64'(out_data[23:0]), 64'h004000);
        chk("dflt_const_ch1", 64'(out_data[47:24]), 64'h004000);

        // ---- shift ----
        do_frame(4'd2, 0, "shift");
        chk("shift_const_ch0", 64'(out_data[23:0]), 64'h010000);
        chk("shift_const_ch1", 64'(out_data[47:24]), 64'h010000);
        chk("shift_sat_const", 64'(sat_flag), 64'd0);

        // ---- full-scale saturation ----
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < NB; b++) begin
                write_gain(c, b, 16'h7FFF);
                smp[c][b] = 48'sh7FFF_FFFF_FFFF;
            end
        do_frame(4'd4, 0, "sat");
`ifdef EQ_GAIN_MIXER_SATURATE_EN
        chk("sat_const_ch0", 64'(out_data[23:0]), 64'h7FFFFF);
        chk("sat_const_flag", 64'(sat_flag), 64'd1);
`else
        chk("wrap_const_ch0", 64'(out_data[23:0]), 64'hFFDFFF);
        chk("wrap_const_flag", 64'(sat_flag), 64'd0);
`endif

        // ---- gain update during MAC, then next frame ----
        rand_gains();
        rand_samples();
        smp[1][0] = 48'sh0000_4000_0000;
        wch = 1; wband = 0; wval = sh_m[1][0] ^ 16'h1234;
        rsh = 4'($urandom_range(0, 6));
        do_frame(rsh, 2, "gupd_cur");
        do_frame(rsh, 0, "gupd_next");

        // ---- gain write coincident with acceptance ----
        wch = 1; wband = 0; wval = sh_m[1][0] ^ 16'h0F0F;
        do_frame(rsh, 1, "gcoin");

        // ---- overrun ----
        rand_samples();
        do_frame(4'($urandom_range(0, 15)), 3, "ovr");

        // ---- random frames ----
        for (int i = 0; i < 6; i++) begin
            rand_gains();
            rand_samples();
            do_frame(4'($urandom_range(0, 15)), 0, $sformatf("rand%0d", i));
        end

        // ---- abort with run low in MAC ----
        prev = out_data;
        rand_samples();
        pack_frame();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        run = 1'b0;
        tick();
        chk("abort_ready_low", 64'(in_ready), 64'd0);
        run = 1'b1;
        #1;
        chk("abort_ready_back", 64'(in_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        chk("abort_nvalid", 64'(cnt), 64'd0);
        chk("abort_data_kept", 64'(out_data), 64'(prev));

        // ---- reset in the middle of a frame ----
        rand_samples();
        pack_frame();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_sat", 64'(sat_flag), 64'd0);
        chk("midrst_overrun", 64'(overrun), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        sh_m = '{default: '0};
        tick();
        reset_n = 1'b1;
        tick();

        // gains cleared by reset: any frame mixes to zero
        rand_samples();
        do_frame(4'd3, 0, "post_rst_zero");
        rand_gains();
        rand_samples();
        do_frame(4'($urandom_range(0, 15)), 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
